// File: rtl/core_ma_lsu_ctrl.sv
// rtl/core_ma_lsu_ctrl.sv - LSU memory-access-stage Avalon-MM bus sequencer
//
// Purpose:
//   Takes one load/store request from the pipeline and runs it on Avalon-MM
//   master port m0. An access that straddles a 32-bit word boundary is split
//   into two word-aligned beats (word A, then word A+4). The pipeline is held
//   until the access completes. Read data is merged downstream.
//
// Ports:
//   clk, rest                 clock, synchronous active-high reset
//   mem_read / mem_write      level request, held until mem_done
//   mem_addr                  byte address
//   mem_op_data_len           access length in bytes (1, 2 or 4)
//   mem_write_data            right-aligned store data
//   mem_stall                 pipeline hold
//   mem_done                  one-cycle completion pulse
//   mem_cross_word            current access spans two words
//   avl_m0_*                  Avalon-MM master (address, read, write,
//                             byte_enable, write_data, waitrequest,
//                             read_data_valid)
module core_ma_lsu_ctrl #(
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic        clk,
   input  logic        rest,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_addr,
   input  logic [2:0]  mem_op_data_len,
   input  logic [31:0] mem_write_data,
   output logic        mem_stall,
   output logic        mem_done,
   output logic        mem_cross_word,
   output logic [31:0] avl_m0_address,
   output logic        avl_m0_read,
   output logic        avl_m0_write,
   output logic [3:0]  avl_m0_byte_enable,
   output logic [31:0] avl_m0_write_data,
   input  logic        avl_m0_waitrequest,
   input  logic        avl_m0_read_data_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BEAT0,
      S_BEAT1,
      S_WAIT_RD,
      S_DONE
   } state_t;

   localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        cross_q, cross_d;
   logic [31:0] base_q, base_d;
   logic [1:0]  off_q, off_d;
   logic        rd_q, rd_d;
   logic [2:0]  len_q, len_d;
   logic [31:0] wdata_q, wdata_d;

   logic [2:0]  span_end;
   logic [7:0]  len_mask;
   logic [7:0]  be_mask;
   logic [63:0] wdata_sh;
   logic        beat1_issue;
   logic        rd_acc;
   logic        rd_ret;

   // End position of the access within a two-word window; past 4 means the
   // access spills into the next word.
   assign span_end = {1'b0, mem_addr[1:0]} + mem_op_data_len;

   always_comb begin
      len_mask = 8'h0F;
      case (len_q)
         3'd1:    len_mask = 8'h01;
         3'd2:    len_mask = 8'h03;
         default: len_mask = 8'h0F;
      endcase
   end

   assign be_mask  = len_mask << off_q;
   assign wdata_sh = {32'd0, wdata_q} << {off_q, 3'b000};

   // A second read beat must not push the outstanding count past the limit.
   assign beat1_issue = !rd_q || (cnt_q != MAX_CNT);

   always_ff @(posedge clk) begin
      if (rest) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         cross_q <= 1'b0;
         base_q  <= 32'd0;
         off_q   <= 2'd0;
         rd_q    <= 1'b0;
         len_q   <= 3'd0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cross_q <= cross_d;
         base_q  <= base_d;
         off_q   <= off_d;
         rd_q    <= rd_d;
         len_q   <= len_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d            = state_q;
      cross_d            = cross_q;
      base_d             = base_q;
      off_d              = off_q;
      rd_d               = rd_q;
      len_d              = len_q;
      wdata_d            = wdata_q;
      mem_done           = 1'b0;
      avl_m0_address     = 32'd0;
      avl_m0_read        = 1'b0;
      avl_m0_write       = 1'b0;
      avl_m0_byte_enable = 4'h0;
      avl_m0_write_data  = 32'd0;

      case (state_q)
         S_IDLE: begin
            if (mem_read || mem_write) begin
               cross_d = span_end > 3'd4;
               base_d  = {mem_addr[31:2], 2'b00};
               off_d   = mem_addr[1:0];
               rd_d    = mem_read;
               len_d   = mem_op_data_len;
               wdata_d = mem_write_data;
               state_d = S_BEAT0;
            end
         end
         S_BEAT0: begin
            avl_m0_address     = base_q;
            avl_m0_read        = rd_q;
            avl_m0_write       = !rd_q;
            avl_m0_byte_enable = rd_q ? 4'hF : be_mask[3:0];
            avl_m0_write_data  = rd_q ? 32'd0 : wdata_sh[31:0];
            if (!avl_m0_waitrequest) begin
               if (cross_q)   state_d = S_BEAT1;
               else if (rd_q) state_d = S_WAIT_RD;
               else           state_d = S_DONE;
            end
         end
         S_BEAT1: begin
            avl_m0_address     = base_q + 32'd4;
            avl_m0_read        = rd_q && beat1_issue;
            avl_m0_write       = !rd_q;
            avl_m0_byte_enable = rd_q ? 4'hF : be_mask[7:4];
            avl_m0_write_data  = rd_q ? 32'd0 : wdata_sh[63:32];
            if (beat1_issue && !avl_m0_waitrequest) begin
               state_d = rd_q ? S_WAIT_RD : S_DONE;
            end
         end
         S_WAIT_RD: begin
            // Leave once the last outstanding read has returned.
            if ((avl_m0_read_data_valid && cnt_q == 2'd1) || cnt_q == 2'd0) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            mem_done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Accept and return in the same cycle net to no change; a return with
   // nothing outstanding is a stray and is dropped.
   assign rd_acc = avl_m0_read && !avl_m0_waitrequest;
   assign rd_ret = avl_m0_read_data_valid && (cnt_q != 2'd0);
   assign cnt_d  = cnt_q + {1'b0, rd_acc} - {1'b0, rd_ret};

   assign mem_cross_word = (state_q != S_IDLE) && cross_q;
   assign mem_stall      = (mem_read || mem_write) && !mem_done;

endmodule

// File: tb/tb_core_ma_lsu_ctrl.sv
// tb/tb_core_ma_lsu_ctrl.sv - self-checking bench for core_ma_lsu_ctrl
module tb_core_ma_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rest;
   logic        mem_read, mem_write;
   logic [31:0] mem_addr;
   logic [2:0]  mem_op_data_len;
   logic [31:0] mem_write_data;
   logic        mem_stall, mem_done, mem_cross_word;
   logic [31:0] avl_m0_address;
   logic        avl_m0_read, avl_m0_write;
   logic [3:0]  avl_m0_byte_enable;
   logic [31:0] avl_m0_write_data;
   logic        avl_m0_waitrequest, avl_m0_read_data_valid;

   always #5 clk = ~clk;

   core_ma_lsu_ctrl #(.MAX_OUTSTANDING(2)) dut (
      .clk                    (clk),
      .rest                   (rest),
      .mem_read               (mem_read),
      .mem_write              (mem_write),
      .mem_addr               (mem_addr),
      .mem_op_data_len        (mem_op_data_len),
      .mem_write_data         (mem_write_data),
      .mem_stall              (mem_stall),
      .mem_done               (mem_done),
      .mem_cross_word         (mem_cross_word),
      .avl_m0_address         (avl_m0_address),
      .avl_m0_read            (avl_m0_read),
      .avl_m0_write           (avl_m0_write),
      .avl_m0_byte_enable     (avl_m0_byte_enable),
      .avl_m0_write_data      (avl_m0_write_data),
      .avl_m0_waitrequest     (avl_m0_waitrequest),
      .avl_m0_read_data_valid (avl_m0_read_data_valid)
   );

   typedef struct {
      logic        rd;
      logic [31:0] addr;
      logic [2:0]  len;
      logic [31:0] wdata;
      int          wait_n;
      logic        exp_cross;
      int          exp_lat;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
      logic        rd;
   } beat_t;

   beat_t exp_q[$];
   vec_t  vecs[10];
   int    n_vec  = 0;
   int    n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Byte-by-byte placement model of the beats a request should produce.
   task automatic push_expected(input vec_t v);
      logic [7:0]  be8;
      logic [63:0] d64;
      logic [31:0] base;
      int          p;
      beat_t       b;
      be8  = 8'h00;
      d64  = 64'd0;
      base = {v.addr[31:2], 2'b00};
      for (int i = 0; i < int'(v.len); i++) begin
         p = int'(v.addr[1:0]) + i;
         be8[p] = 1'b1;
         d64[p*8 +: 8] = v.wdata[i*8 +: 8];
      end
      b.addr = base;
      b.be   = v.rd ? 4'hF : be8[3:0];
      b.data = d64[31:0];
      b.rd   = v.rd;
      exp_q.push_back(b);
      if (be8[7:4] != 4'h0) begin
         b.addr = base + 32'd4;
         b.be   = v.rd ? 4'hF : be8[7:4];
         b.data = d64[63:32];
         exp_q.push_back(b);
      end
   endtask

   // Entered just after a posedge with the DUT idle; returns likewise.
   task automatic run_vec(input vec_t v, input string tag);
      int    cyc;
      int    wait_left;
      int    outst;
      bit    done_seen;
      bit    rd_acc;
      beat_t h;
      push_expected(v);
      mem_read               = v.rd;
      mem_write              = !v.rd;
      mem_addr               = v.addr;
      mem_op_data_len        = v.len;
      mem_write_data         = v.wdata;
      wait_left              = v.wait_n;
      avl_m0_waitrequest     = (v.wait_n > 0);
      avl_m0_read_data_valid = 1'b0;
      cyc       = 0;
      outst     = 0;
      done_seen = 0;
      while (!done_seen && cyc < 40) begin
         @(negedge clk);
         rd_acc = 0;
         if (avl_m0_read || avl_m0_write) begin
            if (exp_q.size() == 0) begin
               check({tag, " unexpected beat"}, 1, 0);
            end else begin
               h = exp_q[0];
               check({tag, " addr"}, avl_m0_address, h.addr);
               check({tag, " be"}, avl_m0_byte_enable, h.be);
               check({tag, " rd"}, avl_m0_read, h.rd);
               check({tag, " wr"}, avl_m0_write, !h.rd);
               if (!h.rd) check({tag, " wdata"}, avl_m0_write_data, h.data);
               if (!avl_m0_waitrequest) begin
                  void'(exp_q.pop_front());
                  rd_acc = avl_m0_read;
               end else if (wait_left > 0) begin
                  wait_left--;
               end
            end
         end
         if (avl_m0_read_data_valid) outst--;
         if (rd_acc) outst++;
         check({tag, " outstanding<=2"}, 64'(outst <= 2), 1);
         if (cyc == 1) begin
            check({tag, " stall"}, mem_stall, 1);
            check({tag, " cross"}, mem_cross_word, v.exp_cross);
         end
         if (mem_done) begin
            done_seen = 1;
            check({tag, " latency"}, 64'(cyc), 64'(v.exp_lat));
            check({tag, " done stall"}, mem_stall, 0);
            check({tag, " done cross"}, mem_cross_word, v.exp_cross);
            check({tag, " beats left"}, 64'(exp_q.size()), 0);
         end
         @(posedge clk);
         #1;
         if (done_seen) begin
            mem_read  = 1'b0;
            mem_write = 1'b0;
         end
         avl_m0_read_data_valid = rd_acc;
         avl_m0_waitrequest     = (wait_left > 0);
         cyc++;
      end
      if (!done_seen) begin
         check({tag, " timeout"}, 0, 1);
         mem_read  = 1'b0;
         mem_write = 1'b0;
         exp_q.delete();
      end
      avl_m0_read_data_valid = 1'b0;
      @(negedge clk);
      check({tag, " done pulse"}, mem_done, 0);
      check({tag, " bus idle"}, {avl_m0_read, avl_m0_write}, 2'b00);
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t lw;
      //         rd    addr           len   wdata          wait cross lat
      vecs[0] = '{1'b1, 32'h0000_0100, 3'd4, 32'h0,         0, 1'b0, 3};
      vecs[1] = '{1'b1, 32'h0000_0102, 3'd4, 32'h0,         0, 1'b1, 4};
      vecs[2] = '{1'b0, 32'h0000_0103, 3'd2, 32'h0000_BEEF, 0, 1'b1, 3};
      vecs[3] = '{1'b0, 32'h0000_0001, 3'd1, 32'h0000_005A, 3, 1'b0, 5};
      vecs[4] = '{1'b1, 32'hFFFF_FFFE, 3'd4, 32'h0,         0, 1'b1, 4};
      vecs[5] = '{1'b0, 32'h0000_0200, 3'd4, 32'h1234_5678, 0, 1'b0, 2};
      vecs[6] = '{1'b1, 32'h0000_0003, 3'd2, 32'h0,         0, 1'b1, 4};
      vecs[7] = '{1'b1, 32'h0000_0007, 3'd1, 32'h0,         0, 1'b0, 3};
      vecs[8] = '{1'b0, 32'h0000_0002, 3'd2, 32'h0000_CAFE, 0, 1'b0, 2};
      vecs[9] = '{1'b0, 32'h0000_0401, 3'd4, 32'hA1B2_C3D4, 1, 1'b1, 4};

      rest                   = 1'b1;
      mem_read               = 1'b0;
      mem_write              = 1'b0;
      mem_addr               = 32'd0;
      mem_op_data_len        = 3'd0;
      mem_write_data         = 32'd0;
      avl_m0_waitrequest     = 1'b0;
      avl_m0_read_data_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset avl", {avl_m0_address, avl_m0_read, avl_m0_write,
                          avl_m0_byte_enable, avl_m0_write_data}, 0);
      check("reset done/cross", {mem_done, mem_cross_word, mem_stall}, 0);
      rest = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset while a read is outstanding, then a stray return.
      mem_read           = 1'b1;
      mem_addr           = 32'h0000_0100;
      mem_op_data_len    = 3'd4;
      avl_m0_waitrequest = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst wait_rd stall", mem_stall, 1);
      check("rst wait_rd no read", avl_m0_read, 0);
      rest     = 1'b1;
      mem_read = 1'b0;
      @(posedge clk);
      #1;
      rest                   = 1'b0;
      avl_m0_read_data_valid = 1'b1;
      @(negedge clk);
      check("rst outputs", {avl_m0_read, avl_m0_write, mem_done, mem_cross_word}, 0);
      @(posedge clk);
      #1;
      avl_m0_read_data_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("rst no done", mem_done, 0);
      end
      @(posedge clk);
      #1;
      lw = vecs[0];
      run_vec(lw, "post-reset lw");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
